rca_seq_adder: RTL and testbench
================================

Name: rca_seq_adder

Overview:
Sequencer that performs WIDTH-bit add/subtract by iterating a single 4-bit ripple-carry adder (RCA) over the operands, one nibble per clock, LSB nibble first. The carry is chained between nibbles through a register. Operands and results move on valid/ready handshakes. It sits between an operand source (test driver or upstream datapath) and a result sink, and trades area for latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived number of RCA iterations; not overridable

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  sequencer can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
op_sub  input  1  1 = A-B, 0 = A+B+cin
cin  input  1  carry-in for add; ignored when op_sub=1
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
sum  output  WIDTH  result
cout  output  1  final carry out; for subtract, 1 = no borrow
overflow  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Datapath: exactly one 4-bit RCA instance (4 chained full adders, 5-bit result). No second adder. No full-width adder.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- Reset (rst_n low, asynchronous): state goes to IDLE; sum, cout, overflow, out_valid = 0; nibble index = 0; carry register = 0; in_ready = 1; busy = 0. Reset takes effect immediately, including mid-RUN; the partial result is discarded.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready at a rising edge: latch A; latch B_eff = op_sub ? ~op_b : op_b; carry = op_sub ? 1 : cin; clear nibble index; go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle the RCA adds nibble[i] of A, nibble[i] of B_eff, and the carry register.
  - RCA r[3:0] is written to sum[4i+3:4i]. r[4] goes to the carry register. i increments.
  - After nibble NIBBLES-1: cout = r[4]; overflow = (A[W-1] == B_eff[W-1]) && (sum[W-1] != A[W-1]); go to DONE.
- DONE:
  - out_valid = 1. sum, cout and overflow are held stable.
  - On out_valid & out_ready: go to IDLE and deassert out_valid.
  - No new operands are accepted in the same cycle; in_ready rises the following cycle.
- Latency: out_valid is asserted exactly NIBBLES cycles after the accepting edge. For WIDTH=16 that is 4 cycles.
- Throughput: one operation per NIBBLES+2 cycles minimum.
- sum bits not yet written in RUN may hold stale values. They are only valid while out_valid=1.
- Back-pressure: out_ready low holds DONE indefinitely. No output changes.
- Wrap-around: the sum is modulo 2^WIDTH. The carry beyond the MSB appears only on cout.
- WIDTH=4 degenerates to a single RUN cycle with identical rules.

Test Plan:
- Reset: hold rst_n low with random inputs, release -> out_valid=0, sum=0, cout=0, overflow=0, busy=0, in_ready=1. Reassert asynchronously between clock edges -> outputs clear without waiting for an edge.
- Add, WIDTH=16: A=0x1234, B=0x0FFF, sub=0, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x2233, cout=0, overflow=0. Check intermediate carries across nibbles 0–2.
- Full carry ripple: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Separately, A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, overflow=1.
- Subtract: A=0x0005, B=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Separately, A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
- Handshake: keep in_valid=1 throughout and hold out_ready=0 for 5 cycles in DONE -> in_ready=0, sum stable, only one operation accepted. Raising out_ready -> out_valid drops next edge and in_ready=1 one cycle later.
- Mid-operation reset: assert rst_n low after 2 RUN cycles -> immediate IDLE, out_valid never asserted. Next operation A=0x00FF, B=0x0001 -> sum=0x0100, cout=0, with no carry leaked from the aborted op.

Source files
------------

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - Nibble-serial add/subtract sequencer built around one 4-bit ripple-carry adder
//
// Purpose:
//   Computes A+B+cin or A-B over WIDTH bits by running a single 4-bit RCA once
//   per clock, LSB nibble first, with the carry chained through a register.
//   Operands arrive on an in_valid/in_ready handshake and the result leaves on
//   an out_valid/out_ready handshake. Latency from accept to out_valid is
//   NIBBLES cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand set valid
//   in_ready  out  sequencer idle and able to accept operands
//   op_a      in   [WIDTH] operand A
//   op_b      in   [WIDTH] operand B
//   op_sub    in   1 = A-B, 0 = A+B+cin
//   cin       in   carry-in for add, ignored for subtract
//   out_valid out  result valid
//   out_ready in   sink accepts result
//   sum       out  [WIDTH] result, modulo 2^WIDTH
//   cout      out  carry out of the MSB (for subtract, 1 = no borrow)
//   overflow  out  two's-complement signed overflow
//   busy      out  operation in progress or result pending
module rca_seq_adder #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // B already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       a_nib, b_nib;
  logic [4:0]       rca_r;

  // The one and only adder: four chained full adders on the current nibble.
  always_comb begin
    logic c;
    a_nib = a_q[idx_q*4 +: 4];
    b_nib = b_q[idx_q*4 +: 4];
    c     = carry_q;
    rca_r = '0;
    for (int k = 0; k < 4; k++) begin
      rca_r[k] = a_nib[k] ^ b_nib[k] ^ c;
      c        = (a_nib[k] & b_nib[k]) | (c & (a_nib[k] ^ b_nib[k]));
    end
    rca_r[4] = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          // Subtract is A + ~B + 1, so the +1 rides in on the carry register.
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*4 +: 4] = rca_r[3:0];
        carry_d             = rca_r[4];
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = rca_r[4];
          // rca_r[3] is the MSB of sum being written this cycle.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (rca_r[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - Directed self-checking bench for rca_seq_adder (WIDTH=16)
module tb_rca_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;

  rca_seq_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) accepts <= accepts + 1;
  end

  // Present operands before an edge and let exactly one rising edge accept them.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic c, input string name);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; cin = c; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready got=%b exp=1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, checking latency and results, then complete the handshake.
  task automatic finish_op(input logic [15:0] es, input logic ec, input logic eo,
                           input string name);
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=4", name, lat);
    end
    checks++;
    if (sum !== es || cout !== ec || overflow !== eo) begin
      failures++;
      $display("FAIL %s_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
               name, sum, cout, overflow, es, ec, eo);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release got out_valid=%b in_ready=%b busy=%b exp 0/1/0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
      op_sub = 1'($urandom); cin = 1'($urandom); out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || overflow !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got ov=%b sum=%h cout=%b ovf=%b busy=%b ir=%b exp 0/0000/0/0/0/1",
               out_valid, sum, cout, overflow, busy, in_ready);
    end
    // Bring the DUT to DONE with non-zero outputs, then reset between edges.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "async_rst_setup");
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL async_rst_pre got out_valid=%b exp=1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_rst got ov=%b sum=%h cout=%b busy=%b ir=%b exp 0/0000/0/0/1",
               out_valid, sum, cout, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_intermediate();
    logic [3:0] exp_nib [3] = '{4'h3, 4'h3, 4'h2};
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "add_1234");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (sum[k*4 +: 4] !== exp_nib[k] || dut.carry_q !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL add_nibble%0d got nib=%h carry=%b ov=%b exp nib=%h carry=1 ov=0",
                 k, sum[k*4 +: 4], dut.carry_q, out_valid, exp_nib[k]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h2233 || cout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL add_1234_result got ov=%b sum=%h cout=%b ovf=%b exp 1/2233/0/0",
               out_valid, sum, cout, overflow);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_carry_ripple();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple_ffff");
    finish_op(16'h0000, 1'b1, 1'b0, "ripple_ffff");
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_7fff");
    finish_op(16'h8000, 1'b0, 1'b1, "ovf_7fff");
    start_op(16'h0001, 16'h0001, 1'b0, 1'b1, "add_cin");
    finish_op(16'h0003, 1'b0, 1'b0, "add_cin");
  endtask

  task automatic test_subtract();
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_5_7");
    finish_op(16'hFFFE, 1'b0, 1'b0, "sub_5_7");
    start_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_8000_1");
    finish_op(16'h7FFF, 1'b1, 1'b1, "sub_8000_1");
  endtask

  task automatic test_back_to_back();
    int acc0;
    acc0 = accepts;
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0002; op_sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0003 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d got ov=%b ir=%b sum=%h busy=%b exp 1/0/0003/1",
                 i, out_valid, in_ready, sum, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got ov=%b ir=%b exp 0/1", out_valid, in_ready);
    end
    checks++;
    if (accepts - acc0 != 1) begin
      failures++;
      $display("FAIL hold_accepts got=%0d exp=1", accepts - acc0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "mid_rst_setup");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_idle got busy=%b ir=%b ov=%b exp 0/1/0", busy, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_rst_no_valid%0d got=%b exp=0", i, out_valid);
      end
    end
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "post_rst");
    finish_op(16'h0100, 1'b0, 1'b0, "post_rst");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0; cin = 1'b0;
    test_reset();
    test_add_intermediate();
    test_carry_ripple();
    test_subtract();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
